// File: rtl/bindct_2d_row_ctrl.sv
// -----------------------------------------------------------------------------
// bindct_2d_row_ctrl
//
// Row-pass sequencer for an 8x8 binDCT block. Accepts eight pixel rows from
// the block fetcher, hands each one to the shared 1D row engine with a
// one-cycle load, captures every engine result into an 8x8 transpose buffer
// and finally streams that buffer out column by column to the column pass.
//
// Optional feature (macro BINDCT_WDOG_EN): engine-response watchdog. When the
// engine fails to answer within WDOG_CYCLES WAIT cycles, the partial block is
// dropped, the sequencer returns to FETCH and the sticky err flag is raised.
// Without the macro, WAIT waits indefinitely and err is tied to 0.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. row_ready/col_valid/dct_ready depend only on state (and, for
// dct_ready, combinationally on dct_valid); data is held stable while
// valid is high and ready is low.
//
// Ports:
//   clk        clock
//   rst        synchronous reset, active-low (engine gets the inverted copy)
//   row_in     pixel row from upstream, element k = x[k] (two's complement)
//   row_valid  upstream row available
//   row_ready  controller accepts a row this cycle (FETCH only)
//   dct_x      registered row presented to engine x_in
//   dct_load   one-cycle load strobe to engine
//   dct_y      engine y_out
//   dct_valid  engine valid_out
//   dct_ready  engine ready_in, result consumed (WAIT only)
//   col_out    column c of buffer: col_out[r] = buf[r][c]
//   col_valid  column available (DRAIN only)
//   col_ready  downstream accepts column
//   col_idx    current column index c
//   col_last   col_valid && c == 7
//   err        sticky watchdog error
// -----------------------------------------------------------------------------
module bindct_2d_row_ctrl #(
  parameter int IN_WIDTH    = 8,
  parameter int OUT_WIDTH   = 20,
  parameter int WDOG_CYCLES = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0][IN_WIDTH-1:0]      row_in,
  input  logic                          row_valid,
  output logic                          row_ready,
  output logic [7:0][IN_WIDTH-1:0]      dct_x,
  output logic                          dct_load,
  input  logic [7:0][OUT_WIDTH-1:0]     dct_y,
  input  logic                          dct_valid,
  output logic                          dct_ready,
  output logic [7:0][OUT_WIDTH-1:0]     col_out,
  output logic                          col_valid,
  input  logic                          col_ready,
  output logic [2:0]                    col_idx,
  output logic                          col_last,
  output logic                          err
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_LOAD  = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t state;
  state_t state_n;

  logic [2:0] r;   // buffer row being filled
  logic [2:0] c;   // buffer column being drained

  // Transpose buffer: mem[r] holds engine result of row r, element k at [k].
  logic [7:0][OUT_WIDTH-1:0] mem [8];

  // Asserted in the WAIT cycle where the engine has run out of time.
  logic wd_expire;

`ifdef BINDCT_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES);

  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  assign wd_expire = (state == S_WAIT) && !dct_valid &&
                     (wd_cnt == WD_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == S_LOAD) begin
        wd_cnt <= '0;
      end else if ((state == S_WAIT) && !dct_valid) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (wd_expire) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  // Keeps the watchdog limit referenced so the parameter stays meaningful
  // in builds without the watchdog.
  logic unused_wdog;
  assign unused_wdog = (WDOG_CYCLES > 5);
  assign wd_expire   = 1'b0;
  assign err         = 1'b0;
`endif

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_FETCH;
      r     <= 3'd0;
      c     <= 3'd0;
      dct_x <= '0;
      for (int i = 0; i < 8; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state <= state_n;
      case (state)
        S_FETCH: begin
          if (row_valid) begin
            dct_x <= row_in;
          end
        end
        S_WAIT: begin
          if (dct_valid) begin
            mem[r] <= dct_y;
            r      <= (r == 3'd7) ? 3'd0 : r + 3'd1;
          end else if (wd_expire) begin
            // Partial block discarded: next accepted row restarts at row 0.
            r <= 3'd0;
          end
        end
        S_DRAIN: begin
          if (col_ready) begin
            c <= (c == 3'd7) ? 3'd0 : c + 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_n   = state;
    row_ready = 1'b0;
    dct_load  = 1'b0;
    dct_ready = 1'b0;
    col_valid = 1'b0;
    case (state)
      S_FETCH: begin
        row_ready = 1'b1;
        if (row_valid) begin
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        dct_load = 1'b1;
        state_n  = S_WAIT;
      end
      S_WAIT: begin
        // Ready mirrors valid so the result is consumed the cycle it appears;
        // the following FETCH cycle provides the mandatory gap before the
        // next load.
        dct_ready = dct_valid;
        if (dct_valid) begin
          state_n = (r == 3'd7) ? S_DRAIN : S_FETCH;
        end else if (wd_expire) begin
          state_n = S_FETCH;
        end
      end
      S_DRAIN: begin
        col_valid = 1'b1;
        if (col_ready && (c == 3'd7)) begin
          state_n = S_FETCH;
        end
      end
      default: begin
        state_n = S_FETCH;
      end
    endcase
  end

  // Column read-out: transpose by selecting element c of every stored row.
  always_comb begin
    for (int rr = 0; rr < 8; rr++) begin
      col_out[rr] = mem[rr][c];
    end
  end

  assign col_idx  = c;
  assign col_last = col_valid && (c == 3'd7);

endmodule

// File: tb/tb_bindct_2d_row_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bindct_2d_row_ctrl
//
// Directed bench for bindct_2d_row_ctrl. A small engine stub answers each
// load five cycles later with y[0] = 64*sum(x) and y[k] = 8*k*(x[k]-x[k-1]),
// holding valid until ready. A constant row of ones therefore yields 512 in
// y[0] and 0 elsewhere. Inputs are driven and outputs sampled just after the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_bindct_2d_row_ctrl;

  localparam int IW = 8;
  localparam int OW = 20;

  logic                   clk;
  logic                   rst;
  logic [7:0][IW-1:0]     row_in;
  logic                   row_valid;
  logic                   row_ready;
  logic [7:0][IW-1:0]     dct_x;
  logic                   dct_load;
  logic [7:0][OW-1:0]     dct_y;
  logic                   dct_valid;
  logic                   dct_ready;
  logic [7:0][OW-1:0]     col_out;
  logic                   col_valid;
  logic                   col_ready;
  logic [2:0]             col_idx;
  logic                   col_last;
  logic                   err;

  int n_checks = 0;
  int n_errors = 0;

  bindct_2d_row_ctrl #(
    .IN_WIDTH    (IW),
    .OUT_WIDTH   (OW),
    .WDOG_CYCLES (15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .dct_x     (dct_x),
    .dct_load  (dct_load),
    .dct_y     (dct_y),
    .dct_valid (dct_valid),
    .dct_ready (dct_ready),
    .col_out   (col_out),
    .col_valid (col_valid),
    .col_ready (col_ready),
    .col_idx   (col_idx),
    .col_last  (col_last),
    .err       (err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- engine model ----------------
  function automatic int model_y(input logic [7:0][IW-1:0] x, input int k);
    int s;
    s = 0;
    if (k == 0) begin
      for (int i = 0; i < 8; i++) s += $signed(x[i]);
      return 64 * s;
    end
    return ($signed(x[k]) - $signed(x[k-1])) * k * 8;
  endfunction

  logic               stub_en = 1'b1;
  logic               st_pend;
  logic [2:0]         st_cnt;
  logic [7:0][IW-1:0] st_cap;

  always @(posedge clk) begin
    if (!rst) begin
      st_pend <= 1'b0;
      st_cnt  <= 3'd0;
    end else if (dct_load) begin
      st_pend <= stub_en;
      st_cnt  <= 3'd4;
      st_cap  <= dct_x;
    end else if (st_pend && st_cnt != 3'd0) begin
      st_cnt <= st_cnt - 3'd1;
    end else if (st_pend && dct_ready) begin
      st_pend <= 1'b0;
    end
  end

  assign dct_valid = st_pend && (st_cnt == 3'd0);

  always_comb begin
    for (int k = 0; k < 8; k++) dct_y[k] = OW'(model_y(st_cap, k));
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [IW-1:0] pix(input int blk, input int r, input int k);
    case (blk)
      0:       return IW'(1);
      2:       return IW'(r * 13 - k * 9 + 3);
      3:       return IW'(100 - r - k);
      default: return IW'(k * 17 - r * 11 - 20);
    endcase
  endfunction

  function automatic logic [7:0][IW-1:0] make_row(input int blk, input int r);
    logic [7:0][IW-1:0] v;
    for (int k = 0; k < 8; k++) v[k] = pix(blk, r, k);
    return v;
  endfunction

  int exp_buf [8][8];

  task automatic set_exp(input int blk);
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++)
        exp_buf[r][k] = model_y(make_row(blk, r), k);
  endtask

  // ---------------- scoreboard check ----------------
  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  // Waits for FETCH, optionally idles there for 'bubble' cycles, then presents
  // one row. Returns just after the falling edge of the LOAD cycle.
  task automatic feed_row(input logic [7:0][IW-1:0] rowv, input int bubble);
    int t;
    t = 0;
    row_valid = 1'b0;
    while (!row_ready && t < 30) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("fetch_wait", (t < 30), 1);
    for (int i = 0; i < bubble; i++) begin
      chk("bubble_row_ready", row_ready, 1);
      chk("bubble_no_load", dct_load, 0);
      @(negedge clk);
      #1;
    end
    row_in    = rowv;
    row_valid = 1'b1;
    @(negedge clk);
    row_valid = 1'b0;
    #1;
    chk("load_strobe", dct_load, 1);
    chk("dct_x_row", dct_x, rowv);
  endtask

  task automatic check_col(input int c);
    chk("col_valid", col_valid, 1);
    chk("col_idx", col_idx, c);
    chk("col_last", col_last, (c == 7));
    for (int r = 0; r < 8; r++) chk("col_out", $signed(col_out[r]), exp_buf[r][c]);
  endtask

  // Drains one block against exp_buf; column stall_col is held for stall_len.
  task automatic drain(input int stall_col, input int stall_len);
    int t;
    t = 0;
    while (!col_valid && t < 80) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("drain_wait", (t < 80), 1);
    for (int c = 0; c < 8; c++) begin
      if (c == stall_col) begin
        col_ready = 1'b0;
        for (int i = 0; i < stall_len; i++) begin
          #1;
          check_col(c);
          @(negedge clk);
        end
        col_ready = 1'b1;
      end
      #1;
      check_col(c);
      chk("drain_row_ready", row_ready, 0);
      @(negedge clk);
    end
    #1;
    chk("post_drain_col_valid", col_valid, 0);
    chk("post_drain_row_ready", row_ready, 1);
  endtask

  // ---------------- directed sequence ----------------
  int load_q [$];
  int col_first;
  int k_err;

  initial begin
    rst       = 1'b0;
    row_in    = '0;
    row_valid = 1'b0;
    col_ready = 1'b0;

    // Reset: two cycles low.
    do_reset(2);
    chk("rst_row_ready", row_ready, 1);
    chk("rst_dct_load", dct_load, 0);
    chk("rst_col_valid", col_valid, 0);
    chk("rst_dct_ready", dct_ready, 0);
    chk("rst_err", err, 0);
    chk("rst_col_idx", col_idx, 0);
    chk("rst_col_last", col_last, 0);
    chk("rst_dct_x", dct_x, 0);

    // Constant block, zero-wait upstream and downstream. Cycle 0 = first FETCH.
    @(negedge clk);
    row_in    = make_row(0, 0);
    row_valid = 1'b1;
    col_ready = 1'b1;
    col_first = -1;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      #1;
      if (dct_load) load_q.push_back(k);
      if (col_valid) begin
        col_first = k;
        break;
      end
    end
    row_valid = 1'b0;
    chk("load_count", load_q.size(), 8);
    if (load_q.size() > 0) chk("first_load_cycle", load_q[0], 1);
    for (int i = 1; i < load_q.size(); i++) chk("load_spacing", load_q[i] - load_q[i-1], 7);
    chk("col_valid_rise_cycle", col_first, 56);
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++)
        exp_buf[r][k] = (k == 0) ? 512 : 0;
    drain(-1, 0);

    // Distinct block: upstream bubble before row 3, column 3 stalled 10 cycles.
    set_exp(2);
    for (int r = 0; r < 8; r++) feed_row(make_row(2, r), (r == 3) ? 6 : 0);
    drain(3, 10);

    // Mid-block reset during WAIT of row 4; the aborted block must not leak.
    for (int r = 0; r < 5; r++) feed_row(make_row(3, r), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_row_ready", row_ready, 1);
    chk("midrst_col_valid", col_valid, 0);
    chk("midrst_dct_ready", dct_ready, 0);
    set_exp(4);
    for (int r = 0; r < 8; r++) feed_row(make_row(4, r), 0);
    drain(-1, 0);

    // Engine that never answers.
    stub_en = 1'b0;
    feed_row(make_row(2, 1), 0);
`ifdef BINDCT_WDOG_EN
    k_err = 0;
    while (!err && k_err < 40) begin
      @(negedge clk);
      #1;
      k_err++;
    end
    chk("wdog_latency", k_err, 16);
    chk("wdog_row_ready", row_ready, 1);
    chk("wdog_dct_ready", dct_ready, 0);
    repeat (5) @(negedge clk);
    #1;
    chk("wdog_sticky", err, 1);
`else
    repeat (30) @(negedge clk);
    #1;
    chk("nowdog_err", err, 0);
    chk("nowdog_row_ready", row_ready, 0);
    chk("nowdog_dct_ready", dct_ready, 0);
    chk("nowdog_col_valid", col_valid, 0);
`endif
    do_reset(1);
    chk("final_rst_err", err, 0);
    chk("final_rst_row_ready", row_ready, 1);
    stub_en = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
